riscv_tag_check_unit: RTL and testbench

Parametrised DIFT tag-check unit for the RI5CY writeback stage, generalising the single-bit load check to N source operands with multi-bit tags. It flags a policy violation when any enabled operand carries a tag bit selected by the policy mask. The violation is either raised as a held exception toward the controller (trap mode) or only counted (log mode). Cause, PC and overrun status are captured for the exception handler.

---
 rtl/riscv_tag_check_unit_if.sv | 41 ++++
 rtl/riscv_tag_check_unit.sv | 93 +++++++++
 tb/tb_riscv_tag_check_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/riscv_tag_check_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_tag_check_unit_if                                                    |
// | WB-stage tag-check bus: operand tags/policy in, violation/exception out.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface riscv_tag_check_unit_if #(
    parameter int TAG_W = 1,
    parameter int N_SRC = 3,
    parameter int CNT_W = 16
);
    logic                     valid_i;
    logic [N_SRC-1:0]         check_en_i;
    logic [N_SRC*TAG_W-1:0]   tag_i;
    logic [TAG_W-1:0]         tag_mask_i;
    logic                     trap_en_i;
    logic [31:0]              pc_i;
    logic                     exc_ack_i;
    logic                     cnt_clr_i;
    logic                     viol_o;
    logic                     exc_valid_o;
    logic [N_SRC-1:0]         exc_src_o;
    logic [31:0]              exc_pc_o;
    logic                     exc_overrun_o;
    logic [CNT_W-1:0]         viol_cnt_o;

    modport master (
        output valid_i, check_en_i, tag_i, tag_mask_i, trap_en_i, pc_i,
               exc_ack_i, cnt_clr_i,
        input  viol_o, exc_valid_o, exc_src_o, exc_pc_o, exc_overrun_o,
               viol_cnt_o
    );

    modport slave (
        input  valid_i, check_en_i, tag_i, tag_mask_i, trap_en_i, pc_i,
               exc_ack_i, cnt_clr_i,
        output viol_o, exc_valid_o, exc_src_o, exc_pc_o, exc_overrun_o,
               viol_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/riscv_tag_check_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_tag_check_unit                                                       |
// | DIFT tag check over N operands; traps (held exception) or logs violations. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module riscv_tag_check_unit #(
    parameter int TAG_W = 1,
    parameter int N_SRC = 3,
    parameter int CNT_W = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    riscv_tag_check_unit_if.slave   bus
);
    localparam logic [0:0]       c_ST_IDLE = 1'b0;
    localparam logic [0:0]       c_ST_PEND = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [N_SRC-1:0] w_hit;
    logic             w_viol;
    logic             w_trap_viol;

    logic [0:0]       r_state;
    logic [N_SRC-1:0] r_src;
    logic [31:0]      r_pc;
    logic             r_overrun;
    logic [CNT_W-1:0] r_cnt;

    generate
        for (genvar k = 0; k < N_SRC; k++) begin : g_hit
            assign w_hit[k] = bus.check_en_i[k] &
                              (|(bus.tag_i[k*TAG_W +: TAG_W] & bus.tag_mask_i));
        end
    endgenerate

    assign w_viol      = bus.valid_i & (|w_hit);
    assign w_trap_viol = w_viol & bus.trap_en_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_src     <= '0;
            r_pc      <= '0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_trap_viol) begin
                        r_state   <= c_ST_PEND;
                        r_src     <= w_hit;
                        r_pc      <= bus.pc_i;
                        r_overrun <= 1'b0;
                    end
                end
                c_ST_PEND: begin
                    // A same-cycle new event replaces the one being acked
                    if (w_trap_viol && bus.exc_ack_i) begin
                        r_src     <= w_hit;
                        r_pc      <= bus.pc_i;
                        r_overrun <= 1'b0;
                    end else if (w_trap_viol) begin
                        r_overrun <= 1'b1;
                    end else if (bus.exc_ack_i) begin
                        r_state   <= c_ST_IDLE;
                        r_overrun <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (bus.cnt_clr_i) begin
            r_cnt <= w_viol ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (w_viol && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.viol_o        = w_viol;
    assign bus.exc_valid_o   = (r_state == c_ST_PEND);
    assign bus.exc_src_o     = r_src;
    assign bus.exc_pc_o      = r_pc;
    assign bus.exc_overrun_o = r_overrun;
    assign bus.viol_cnt_o    = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_riscv_tag_check_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_riscv_tag_check_unit                                                    |
// | Directed vector table plus a small-counter saturation sequence.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_riscv_tag_check_unit;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    riscv_tag_check_unit_if #(.TAG_W(2), .N_SRC(3), .CNT_W(16)) bus0 ();
    riscv_tag_check_unit_if #(.TAG_W(2), .N_SRC(3), .CNT_W(3))  bus1 ();

    riscv_tag_check_unit #(.TAG_W(2), .N_SRC(3), .CNT_W(16)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    riscv_tag_check_unit #(.TAG_W(2), .N_SRC(3), .CNT_W(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic [2:0]  en;
        logic [5:0]  tag;
        logic [1:0]  mask;
        logic        trap;
        logic [31:0] pc;
        logic        ack;
        logic        clr;
        logic        viol;
        logic        ev;
        logic [2:0]  src;
        logic [31:0] epc;
        logic        ovr;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic v, input logic [2:0] en,
                                input logic [5:0] tag, input logic [1:0] mask,
                                input logic trap, input logic [31:0] pc,
                                input logic ack, input logic clr,
                                input logic viol, input logic ev, input logic [2:0] src,
                                input logic [31:0] epc, input logic ovr,
                                input logic [15:0] cnt);
        vec_t t;
        t.rst = r; t.valid = v; t.en = en; t.tag = tag; t.mask = mask;
        t.trap = trap; t.pc = pc; t.ack = ack; t.clr = clr;
        t.viol = viol; t.ev = ev; t.src = src; t.epc = epc; t.ovr = ovr; t.cnt = cnt;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step1(input logic v, input logic clr, input logic [2:0] exp_cnt,
                         input string name);
        @(negedge clk);
        bus1.valid_i   = v;
        bus1.cnt_clr_i = clr;
        @(posedge clk);
        #1;
        check(name, {29'd0, bus1.viol_cnt_o}, {29'd0, exp_cnt});
    endtask

    initial begin
        rst = 1'b1;
        bus0.valid_i = 0; bus0.check_en_i = 0; bus0.tag_i = 0; bus0.tag_mask_i = 0;
        bus0.trap_en_i = 0; bus0.pc_i = 0; bus0.exc_ack_i = 0; bus0.cnt_clr_i = 0;
        bus1.valid_i = 0; bus1.check_en_i = 3'b001; bus1.tag_i = 6'h02;
        bus1.tag_mask_i = 2'b10; bus1.trap_en_i = 0; bus1.pc_i = 0;
        bus1.exc_ack_i = 0; bus1.cnt_clr_i = 0;

        //  rst v  en      tag    mask  trp pc         ack clr | viol ev src    epc        ovr cnt
        add(1, 0, 3'b000, 6'h00, 2'b00, 0, 32'h000, 0, 0,   0, 0, 3'b000, 32'h000, 0, 0);
        add(0, 1, 3'b010, 6'h08, 2'b10, 1, 32'h100, 0, 0,   1, 1, 3'b010, 32'h100, 0, 1);
        add(0, 0, 3'b000, 6'h00, 2'b10, 1, 32'h000, 1, 0,   0, 0, 3'b010, 32'h100, 0, 1);
        add(0, 1, 3'b010, 6'h04, 2'b10, 1, 32'h104, 0, 0,   0, 0, 3'b010, 32'h100, 0, 1);
        add(0, 0, 3'b010, 6'h08, 2'b10, 1, 32'h108, 0, 0,   0, 0, 3'b010, 32'h100, 0, 1);
        add(0, 1, 3'b010, 6'h08, 2'b10, 1, 32'h100, 0, 0,   1, 1, 3'b010, 32'h100, 0, 2);
        add(0, 1, 3'b010, 6'h08, 2'b10, 1, 32'h200, 0, 0,   1, 1, 3'b010, 32'h100, 1, 3);
        add(0, 0, 3'b010, 6'h08, 2'b10, 1, 32'h000, 1, 0,   0, 0, 3'b010, 32'h100, 0, 3);
        add(0, 1, 3'b111, 6'h22, 2'b10, 1, 32'h100, 0, 0,   1, 1, 3'b101, 32'h100, 0, 4);
        add(0, 1, 3'b010, 6'h08, 2'b10, 1, 32'h300, 1, 0,   1, 1, 3'b010, 32'h300, 0, 5);
        add(0, 1, 3'b010, 6'h08, 2'b10, 0, 32'h310, 0, 0,   1, 1, 3'b010, 32'h300, 0, 6);
        add(0, 0, 3'b010, 6'h08, 2'b10, 0, 32'h000, 1, 0,   0, 0, 3'b010, 32'h300, 0, 6);
        for (int i = 0; i < 5; i++)
            add(0, 1, 3'b010, 6'h08, 2'b10, 0, 32'h320, 0, 0, 1, 0, 3'b010, 32'h300, 0, 16'(7 + i));
        add(0, 1, 3'b010, 6'h08, 2'b10, 0, 32'h330, 0, 1,   1, 0, 3'b010, 32'h300, 0, 1);
        add(0, 0, 3'b010, 6'h08, 2'b10, 0, 32'h000, 0, 1,   0, 0, 3'b010, 32'h300, 0, 0);
        add(0, 1, 3'b001, 6'h02, 2'b10, 1, 32'h400, 0, 0,   1, 1, 3'b001, 32'h400, 0, 1);
        add(0, 1, 3'b001, 6'h02, 2'b10, 1, 32'h404, 0, 0,   1, 1, 3'b001, 32'h400, 1, 2);
        add(0, 1, 3'b001, 6'h02, 2'b10, 1, 32'h408, 0, 0,   1, 1, 3'b001, 32'h400, 1, 3);
        add(0, 1, 3'b001, 6'h02, 2'b10, 1, 32'h40c, 0, 0,   1, 1, 3'b001, 32'h400, 1, 4);
        add(1, 1, 3'b001, 6'h02, 2'b10, 1, 32'h410, 1, 0,   1, 0, 3'b000, 32'h000, 0, 0);
        add(0, 0, 3'b000, 6'h00, 2'b10, 1, 32'h000, 1, 0,   0, 0, 3'b000, 32'h000, 0, 0);
        add(0, 1, 3'b010, 6'h04, 2'b01, 1, 32'h500, 0, 0,   1, 1, 3'b010, 32'h500, 0, 1);
        add(0, 1, 3'b000, 6'h3f, 2'b11, 1, 32'h504, 1, 0,   0, 0, 3'b010, 32'h500, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst               = vecs[i].rst;
            bus0.valid_i      = vecs[i].valid;
            bus0.check_en_i   = vecs[i].en;
            bus0.tag_i        = vecs[i].tag;
            bus0.tag_mask_i   = vecs[i].mask;
            bus0.trap_en_i    = vecs[i].trap;
            bus0.pc_i         = vecs[i].pc;
            bus0.exc_ack_i    = vecs[i].ack;
            bus0.cnt_clr_i    = vecs[i].clr;
            #1;
            check($sformatf("v%0d viol", i), {31'd0, bus0.viol_o}, {31'd0, vecs[i].viol});
            @(posedge clk);
            #1;
            check($sformatf("v%0d exc_valid", i), {31'd0, bus0.exc_valid_o}, {31'd0, vecs[i].ev});
            check($sformatf("v%0d exc_src", i), {29'd0, bus0.exc_src_o}, {29'd0, vecs[i].src});
            check($sformatf("v%0d exc_pc", i), bus0.exc_pc_o, vecs[i].epc);
            check($sformatf("v%0d overrun", i), {31'd0, bus0.exc_overrun_o}, {31'd0, vecs[i].ovr});
            check($sformatf("v%0d cnt", i), {16'd0, bus0.viol_cnt_o}, {16'd0, vecs[i].cnt});
        end

        // Narrow counter: saturation and clear interplay
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 9; i++)
            step1(1'b1, 1'b0, (i < 7) ? 3'(i + 1) : 3'd7, $sformatf("sat%0d cnt", i));
        step1(1'b1, 1'b1, 3'd1, "clr+viol cnt");
        step1(1'b1, 1'b0, 3'd2, "post-clr cnt");
        step1(1'b0, 1'b1, 3'd0, "clr cnt");
        check("log-mode exc_valid", {31'd0, bus1.exc_valid_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
